// File: rtl/grid_uart_pkg.sv
// Shared types and constants for the grid UART transmitter.
package grid_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/grid_uart_tx_if.sv
// Byte valid/ready handshake from the grid core into the UART transmitter.
interface grid_uart_tx_if;
  import grid_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/grid_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter; a push is refused while full,
// even when a pop happens in the same cycle.
module grid_tx_fifo
  import grid_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [UART_DATA_BITS-1:0]     push_data,
  input  logic                          pop,
  output logic [UART_DATA_BITS-1:0]     pop_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grid_uart_tx.sv
// 8N1 UART transmitter with input FIFO; defining GRID_UART_PARITY_EN inserts an
// even-parity bit and makes the frame 8E1.
module grid_uart_tx
  import grid_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  grid_uart_tx_if.slave               in_bus,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT    = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state;
  tx_state_t                 state_n;
  logic [CNT_W-1:0]          baud_cnt;
  logic [CNT_W-1:0]          baud_cnt_n;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] shift_reg_n;
  logic [2:0]                bit_idx;
  logic [2:0]                bit_idx_n;
  logic                      tx_n;
  logic                      start_frame;
  logic                      pop;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      bit_end;
`ifdef GRID_UART_PARITY_EN
  logic                      parity_bit;
  logic                      parity_bit_n;
`endif

  grid_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_bus.in_valid),
    .push_data (in_bus.in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_bus.in_ready = !fifo_full;
  assign busy            = (state != IDLE) || (fifo_count != '0);
  assign bit_end         = (baud_cnt == '0);

  // Next-state logic; tx_n is the level the line takes after the coming edge,
  // which is what gives the one-clock accept-to-start-bit latency.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = bit_end ? BAUD_RELOAD : (baud_cnt - BAUD_ONE);
    shift_reg_n  = shift_reg;
    bit_idx_n    = bit_idx;
    tx_n         = tx;
    start_frame  = 1'b0;
    pop          = 1'b0;
`ifdef GRID_UART_PARITY_EN
    parity_bit_n = parity_bit;
`endif

    case (state)
      IDLE: begin
        tx_n = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          start_frame = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          tx_n      = shift_reg[0];
        end else begin
          tx_n = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_BIT) begin
`ifdef GRID_UART_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_bit;
`else
            state_n = STOP;
            tx_n    = UART_IDLE_LEVEL;
`endif
          end else begin
            shift_reg_n = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            bit_idx_n   = bit_idx + 3'd1;
            tx_n        = shift_reg[1];
          end
        end else begin
          tx_n = shift_reg[0];
        end
      end
`ifdef GRID_UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = UART_IDLE_LEVEL;
        end else begin
          tx_n = parity_bit;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = UART_IDLE_LEVEL;
          end
        end else begin
          tx_n = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = UART_IDLE_LEVEL;
      end
    endcase

    // Shared frame launch from IDLE and from STOP (back-to-back, no idle gap).
    if (start_frame) begin
      pop          = 1'b1;
      shift_reg_n  = fifo_data;
      baud_cnt_n   = BAUD_RELOAD;
      state_n      = START;
      tx_n         = 1'b0;
`ifdef GRID_UART_PARITY_EN
      parity_bit_n = even_parity(fifo_data);
`endif
    end else begin
      pop = 1'b0;
    end
  end

  // State, baud timer, shifter and registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      shift_reg  <= '0;
      bit_idx    <= 3'd0;
      tx         <= UART_IDLE_LEVEL;
`ifdef GRID_UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      shift_reg  <= shift_reg_n;
      bit_idx    <= bit_idx_n;
      tx         <= tx_n;
`ifdef GRID_UART_PARITY_EN
      parity_bit <= parity_bit_n;
`endif
    end
  end

endmodule
